// File: rtl/axis_hdr_extract.sv
// Single-register AXI4-Stream pass-through stage that parses the L2/L3/L4 header of
// each packet's first beat into sideband metadata and keeps packet/byte/runt counters.
module axis_hdr_extract #(
  parameter int TDATA_WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       meta_valid,
  output logic [47:0]                meta_dst_mac,
  output logic [47:0]                meta_src_mac,
  output logic [15:0]                meta_ethertype,
  output logic                       meta_vlan,
  output logic [11:0]                meta_vlan_id,
  output logic                       meta_is_ipv4,
  output logic [7:0]                 meta_ip_proto,
  output logic [31:0]                meta_src_ip,
  output logic [31:0]                meta_dst_ip,
  output logic                       meta_l4_valid,
  output logic [15:0]                meta_src_port,
  output logic [15:0]                meta_dst_port,
  output logic                       meta_runt,
  input  logic                       stat_clear,
  output logic [31:0]                stat_pkts,
  output logic [47:0]                stat_bytes,
  output logic [15:0]                stat_runts
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int HB = 42;  // deepest header byte used: tagged L4 destination port

  function automatic logic [6:0] popcount(input logic [KW-1:0] keep);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < KW; i++) cnt = cnt + {6'd0, keep[i]};
    return cnt;
  endfunction

  logic        sop_r;
  logic        accept_s;
  logic [6:0]  len_s;
  logic [7:0]  hb_s [HB];
  logic        vlan_s, runt_s, ipv4_s, l4_s;
  logic [15:0] etype_s, etype_out_s;
  logic [11:0] vid_s;
  logic [7:0]  ver_ihl_s, proto_raw_s, proto_s;
  logic [31:0] sip_raw_s, dip_raw_s, ports_raw_s, sip_s, dip_s, ports_s;
  logic [47:0] dst_mac_s, src_mac_s;

  logic                 m_tvalid_r, m_tlast_r, meta_valid_r;
  logic [TDATA_WIDTH-1:0] m_tdata_r;
  logic [KW-1:0]        m_tkeep_r;
  logic [47:0]          dst_mac_r, src_mac_r, stat_bytes_r;
  logic [15:0]          etype_r, src_port_r, dst_port_r, stat_runts_r;
  logic                 vlan_r, ipv4_r, l4_r, runt_r;
  logic [11:0]          vid_r;
  logic [7:0]           proto_r;
  logic [31:0]          sip_r, dip_r, stat_pkts_r;

  assign s_axis_tready = !m_tvalid_r || m_axis_tready;
  assign accept_s      = s_axis_tvalid && s_axis_tready;

  // Header byte lanes; absent lanes read as zero so short frames parse deterministically.
  always_comb begin
    for (int k = 0; k < HB; k++) hb_s[k] = s_axis_tkeep[k] ? s_axis_tdata[8*k +: 8] : 8'h00;
  end

  // Raw header decode: VLAN detection selects the L3 offset (18 tagged, 14 untagged).
  always_comb begin
    len_s       = popcount(s_axis_tkeep);
    runt_s      = s_axis_tlast && (len_s < 7'd14);
    vlan_s      = ({hb_s[12], hb_s[13]} == 16'h8100) && (len_s >= 7'd18);
    dst_mac_s   = {hb_s[0], hb_s[1], hb_s[2], hb_s[3], hb_s[4], hb_s[5]};
    src_mac_s   = {hb_s[6], hb_s[7], hb_s[8], hb_s[9], hb_s[10], hb_s[11]};
    if (vlan_s) begin
      etype_s     = {hb_s[16], hb_s[17]};
      vid_s       = {hb_s[14][3:0], hb_s[15]};
      ver_ihl_s   = hb_s[18];
      proto_raw_s = hb_s[27];
      sip_raw_s   = {hb_s[30], hb_s[31], hb_s[32], hb_s[33]};
      dip_raw_s   = {hb_s[34], hb_s[35], hb_s[36], hb_s[37]};
      ports_raw_s = {hb_s[38], hb_s[39], hb_s[40], hb_s[41]};
    end else begin
      etype_s     = {hb_s[12], hb_s[13]};
      vid_s       = 12'h000;
      ver_ihl_s   = hb_s[14];
      proto_raw_s = hb_s[23];
      sip_raw_s   = {hb_s[26], hb_s[27], hb_s[28], hb_s[29]};
      dip_raw_s   = {hb_s[30], hb_s[31], hb_s[32], hb_s[33]};
      ports_raw_s = {hb_s[34], hb_s[35], hb_s[36], hb_s[37]};
    end
    ipv4_s = !runt_s && (etype_s == 16'h0800) && (ver_ihl_s[7:4] == 4'h4) &&
             (ver_ihl_s[3:0] >= 4'd5) && (len_s >= (vlan_s ? 7'd38 : 7'd34));
    l4_s   = ipv4_s && ((proto_raw_s == 8'd6) || (proto_raw_s == 8'd17)) &&
             (ver_ihl_s[3:0] == 4'd5) && (len_s >= (vlan_s ? 7'd42 : 7'd38));
  end

  // Field qualification: anything not validated by its enable reads as zero.
  always_comb begin
    if (runt_s) begin
      etype_out_s = 16'h0000;
    end else begin
      etype_out_s = etype_s;
    end
    if (ipv4_s) begin
      proto_s = proto_raw_s;
      sip_s   = sip_raw_s;
      dip_s   = dip_raw_s;
    end else begin
      proto_s = 8'h00;
      sip_s   = 32'h0000_0000;
      dip_s   = 32'h0000_0000;
    end
    if (l4_s) begin
      ports_s = ports_raw_s;
    end else begin
      ports_s = 32'h0000_0000;
    end
  end

  // Start-of-packet tracking on the input side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop_r <= 1'b1;
    end else if (accept_s) begin
      sop_r <= s_axis_tlast;
    end
  end

  // Output register: beat and, on SOP beats, freshly parsed metadata load together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_r <= 1'b0;  m_tlast_r <= 1'b0;  meta_valid_r <= 1'b0;
      m_tdata_r  <= '0;    m_tkeep_r <= '0;
      dst_mac_r  <= 48'h0; src_mac_r <= 48'h0; etype_r <= 16'h0;
      vlan_r     <= 1'b0;  vid_r     <= 12'h0; ipv4_r  <= 1'b0;
      proto_r    <= 8'h0;  sip_r     <= 32'h0; dip_r   <= 32'h0;
      l4_r       <= 1'b0;  src_port_r <= 16'h0; dst_port_r <= 16'h0;
      runt_r     <= 1'b0;
    end else if (s_axis_tready) begin
      m_tvalid_r   <= s_axis_tvalid;
      meta_valid_r <= s_axis_tvalid && sop_r;
      if (s_axis_tvalid) begin
        m_tdata_r <= s_axis_tdata;
        m_tkeep_r <= s_axis_tkeep;
        m_tlast_r <= s_axis_tlast;
      end
      if (s_axis_tvalid && sop_r) begin
        dst_mac_r  <= dst_mac_s;   src_mac_r  <= src_mac_s;   etype_r <= etype_out_s;
        vlan_r     <= vlan_s;      vid_r      <= vid_s;       ipv4_r  <= ipv4_s;
        proto_r    <= proto_s;     sip_r      <= sip_s;       dip_r   <= dip_s;
        l4_r       <= l4_s;        src_port_r <= ports_s[31:16];
        dst_port_r <= ports_s[15:0];
        runt_r     <= runt_s;
      end
    end
  end

  // Statistics; a coincident clear discards that cycle's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_r  <= 32'h0;
      stat_bytes_r <= 48'h0;
      stat_runts_r <= 16'h0;
    end else if (stat_clear) begin
      stat_pkts_r  <= 32'h0;
      stat_bytes_r <= 48'h0;
      stat_runts_r <= 16'h0;
    end else if (accept_s) begin
      stat_bytes_r <= stat_bytes_r + {41'd0, len_s};
      if (s_axis_tlast) stat_pkts_r <= stat_pkts_r + 32'd1;
      if (sop_r && runt_s && (stat_runts_r != 16'hFFFF)) stat_runts_r <= stat_runts_r + 16'd1;
    end
  end

  assign m_axis_tdata   = m_tdata_r;
  assign m_axis_tkeep   = m_tkeep_r;
  assign m_axis_tlast   = m_tlast_r;
  assign m_axis_tvalid  = m_tvalid_r;
  assign meta_valid     = meta_valid_r;
  assign meta_dst_mac   = dst_mac_r;
  assign meta_src_mac   = src_mac_r;
  assign meta_ethertype = etype_r;
  assign meta_vlan      = vlan_r;
  assign meta_vlan_id   = vid_r;
  assign meta_is_ipv4   = ipv4_r;
  assign meta_ip_proto  = proto_r;
  assign meta_src_ip    = sip_r;
  assign meta_dst_ip    = dip_r;
  assign meta_l4_valid  = l4_r;
  assign meta_src_port  = src_port_r;
  assign meta_dst_port  = dst_port_r;
  assign meta_runt      = runt_r;
  assign stat_pkts      = stat_pkts_r;
  assign stat_bytes     = stat_bytes_r;
  assign stat_runts     = stat_runts_r;

endmodule

// File: doc/axis_hdr_extract.md
# axis_hdr_extract

Pass-through 512-bit AXI4-Stream stage that parses the Ethernet/VLAN/IPv4/L4 header in the first beat of every packet. It presents the parsed fields as sideband metadata aligned with that beat on its output and keeps running packet, byte and runt statistics. It sits in the packet path between the packet FIFO and `pkt_writer`. Data, `tkeep` and `tlast` pass through unmodified with one cycle of latency and full throughput.

## Interface
- `TDATA_WIDTH`, 512: stream data width; fixed at 512, and `TKEEP` width is `TDATA_WIDTH/8`.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata/tkeep/tlast/tvalid/tready`: input stream; widths 512/64/1/1/1; `tready` is an output.
- `m_axis_tdata/tkeep/tlast/tvalid/tready`: output stream; widths 512/64/1/1/1; `tready` is an input.
- `meta_valid` out 1: high while the output beat is the first beat of a packet.
- `meta_dst_mac`, `meta_src_mac` out 48 each: MAC addresses in network order (byte 0 is the MSB).
- `meta_ethertype` out 16: ethertype after any VLAN tag.
- `meta_vlan` out 1: packet carries a VLAN tag. `meta_vlan_id` out 12: VLAN ID from the tag.
- `meta_is_ipv4` out 1, `meta_ip_proto` out 8, `meta_src_ip` out 32, `meta_dst_ip` out 32: IPv4 header fields.
- `meta_l4_valid` out 1, `meta_src_port` out 16, `meta_dst_port` out 16: TCP/UDP port fields.
- `meta_runt` out 1: first beat is shorter than 14 bytes and has `tlast` set.
- `stat_clear` in 1: synchronous clear of all statistics.
- `stat_pkts` out 32: packet count; wraps.
- `stat_bytes` out 48: byte count; wraps.
- `stat_runts` out 16: runt count; saturates at 0xFFFF.

## Operation
- Byte lane k is `tdata[8k+7:8k]` and maps to packet byte k. `tkeep` is contiguous from lane 0. `len` = popcount(`tkeep`) of the first beat.
- SOP flag:
  - Set by reset.
  - Cleared on an accepted input beat with `tlast`=0.
  - Set on an accepted input beat with `tlast`=1.
- Parsing is combinational on the input beat when SOP=1. The results are registered into the output stage together with the beat.
- VLAN handling:
  - `meta_vlan` = (bytes 12-13 == 0x8100) and `len` ≥ 18.
  - When tagged, `vlan_id` = {byte14[3:0], byte15}, the ethertype comes from bytes 16-17, and L3 offset O = 18. Otherwise the ethertype comes from bytes 12-13 and O = 14.
- `meta_runt` = `tlast` and `len` < 14. A runt reports all meta fields as 0 except the MACs, which capture whatever lanes are present.
- `meta_is_ipv4` requires all of: ethertype 0x0800, byte O[7:4] == 4, IHL = byte O[3:0] ≥ 5, and `len` ≥ O+20.
  - proto = byte O+9.
  - src IP = bytes O+12..O+15; dst IP = bytes O+16..O+19.
  - When `meta_is_ipv4`=0, these fields are 0.
- `meta_l4_valid` requires all of: `meta_is_ipv4`, proto ∈ {6, 17}, IHL == 5, and `len` ≥ O+24.
  - Ports are bytes O+20..21 (source) and O+22..23 (destination).
  - When `meta_l4_valid`=0, the ports are 0.
- Statistics, updated on input acceptance (`s_axis_tvalid && s_axis_tready`):
  - `stat_bytes` += popcount(`tkeep`) on every accepted beat.
  - `stat_pkts` += 1 on an accepted `tlast` beat.
  - `stat_runts` += 1 on an accepted runt beat.
- If `stat_clear` coincides with an update, the clear wins and that update is dropped.

## Timing
- Output stage:
  - One register stage; latency is 1 cycle from input acceptance to `m_axis_tvalid`.
  - `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready` (combinational path from `m_axis_tready`).
  - Full throughput is sustained: 1 beat per cycle while `m_axis_tready`=1.
- AXIS rules:
  - `m_axis_tvalid` never drops without a handshake.
  - `m_axis_t*` and all `meta_*` are stable while `m_axis_tvalid && !m_axis_tready`.
- `meta_valid` = `m_axis_tvalid` && out_sop. `meta_*` fields hold their last value when `meta_valid`=0.
- Reset (asynchronous, at any point, including mid-packet):
  - Outputs go to 0: `m_axis_tvalid`, all `meta_*`, and all `stat_*`.
  - SOP is set to 1.
  - `s_axis_tready` is 1 from the first cycle after release.
  - A partial packet is abandoned; the next accepted beat is treated as SOP.
- A single-beat packet (SOP and `tlast` on the same beat) is both parsed and counted in that cycle.

## Test plan
- **Untagged UDP.** Stimulus: 98-byte packet (2 beats), ethertype 0x0800, IHL 5, proto 17, 10.0.0.1→10.0.0.2, ports 1234→80.
  - Required: `meta_valid` on beat 1 only; `meta_is_ipv4`=1, `meta_l4_valid`=1, src_ip 0x0A000001, dst_port 0x0050.
  - Stats: `stat_pkts`=1, `stat_bytes`=98.
- **VLAN TCP.** Stimulus: 0x8100 tag with TCI 0x0064, inner 0x0800, proto 6.
  - Required: `meta_vlan`=1, `vlan_id`=100, `meta_ethertype`=0x0800, ports taken from bytes 38-41.
- **IPv4 with options, and ARP.** Stimulus: IPv4 with IHL 6, then an ARP frame (0x0806).
  - Required: IPv4 packet gives `meta_is_ipv4`=1 and `meta_l4_valid`=0. ARP gives `meta_is_ipv4`=0 and all IP/port fields 0.
- **Runt.** Stimulus: single beat, `tkeep`=0x3FF (10 bytes), `tlast`=1.
  - Required: `meta_runt`=1, `stat_runts`=1, `stat_pkts`=1, `stat_bytes`=10.
- **Backpressure.** Stimulus: 3-beat packets streamed back-to-back; `m_axis_tready` randomly low about 50% of cycles.
  - Required: output identical to input; no beat lost or duplicated; `meta` stable while stalled; 100% throughput once `tready` is held 1.
- **Reset and clear.** Stimulus: `rst_n` low in the middle of beat 2 of a 3-beat packet; then `stat_clear` in the same cycle as an accepted `tlast`.
  - Required: after reset, all outputs are 0 and the next beat is parsed as SOP. After the clear, all `stat_*` read 0 (the coincident update is dropped).
